// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a held grant and a release turnaround.
// Define ARB_TIMEOUT_EN to cap grant length at HOLD_MAX cycles and pulse tout on a forced release.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       z,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       tout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 16) begin : g_hold_range
        $error("rr_arbiter8: HOLD_MAX must be within 2..16");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_id;
    logic [2:0] w_id_nxt;
    logic       r_turn;
    logic       w_turn_nxt;

    logic       w_found;
    logic [2:0] w_sel;
    logic [2:0] w_idx;
    logic       w_hold_exp;
    logic       w_tout_evt;

    // First set request bit scanning upward from r_ptr with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_idx = r_ptr + 3'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [4:0] r_hold;
    logic       r_tout;

    assign w_hold_exp = (r_hold == 5'(HOLD_MAX));

    // r_hold is the 1-based cycle count of the grant currently visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 5'd0;
        end else if (w_state_nxt == GRANT) begin
            r_hold <= (r_state == GRANT) ? r_hold + 5'd1 : 5'd1;
        end else begin
            r_hold <= 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_tout_evt;
        end
    end

    assign tout = r_tout;
`else
    assign w_hold_exp = 1'b0;
    assign tout       = 1'b0;
`endif

    assign w_tout_evt = (r_state == GRANT) && !z && req[r_id] && w_hold_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_id    <= 3'd0;
            r_turn  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_id_nxt;
            r_turn  <= w_turn_nxt;
        end
    end

    // A disable drop is not a release: no pointer advance and no turnaround.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_id_nxt    = r_id;
        w_turn_nxt  = 1'b0;
        if (z) begin
            w_state_nxt = IDLE;
            w_id_nxt    = 3'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_id_nxt = 3'd0;
                    if (!r_turn && w_found) begin
                        w_state_nxt = GRANT;
                        w_id_nxt    = w_sel;
                    end
                end
                GRANT: begin
                    if (!req[r_id] || w_hold_exp) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = r_id + 3'd1;
                        w_id_nxt    = 3'd0;
                        w_turn_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_id_nxt    = 3'd0;
                end
            endcase
        end
    end

    assign gnt    = (r_state == GRANT) ? (8'd1 << r_id) : 8'd0;
    assign gnt_id = r_id;
    assign busy   = (r_state == GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors for rr_arbiter8 checked through a scoreboard queue.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       z;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       tout;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .z     (z),
        .req   (req),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .busy  (busy),
        .tout  (tout)
    );

    typedef struct {
        int         tag;
        logic [7:0] g;
        logic [2:0] id;
        logic       b;
        logic       t;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks   = 0;
    int   failures = 0;
    int   tag      = 0;

    function automatic logic [7:0] oh(input int i);
        logic [7:0] v;
        v = 8'h01 << i;
        return v;
    endfunction

    task automatic chk(input string nm, input int tg,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, tg, act, exp);
        end
    endtask

    // Inputs for one cycle; expected outputs are those seen after the next edge.
    task automatic step(input logic r, input logic zz, input logic [7:0] rq,
                        input logic [7:0] eg, input logic [2:0] eid,
                        input logic et);
        exp_t e;
        @(negedge clk);
        rst = r;
        z   = zz;
        req = rq;
        e.tag = tag;
        e.g   = eg;
        e.id  = eid;
        e.b   = (eg != 8'd0);
        e.t   = et;
        tag++;
        sbq.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("gnt", me.tag, gnt, me.g);
            chk("gnt_id", me.tag, 8'(gnt_id), 8'(me.id));
            chk("busy", me.tag, 8'(busy), 8'(me.b));
            chk("tout", me.tag, 8'(tout), 8'(me.t));
            chk("onehot", me.tag, 8'($countones(gnt) <= 1), 8'd1);
        end
    end

    initial begin
        rst = 1'b1;
        z   = 1'b0;
        req = 8'h00;

        // reset state and first grant
        step(1, 0, 8'h00, 8'h00, 3'd0, 0);
        step(1, 0, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h05, 8'h01, 3'd0, 0);
        step(0, 0, 8'h05, 8'h01, 3'd0, 0);
        // release, turnaround, next from ptr=1
        step(0, 0, 8'h04, 8'h00, 3'd0, 0);
        step(0, 0, 8'h04, 8'h00, 3'd0, 0);
        step(0, 0, 8'h04, 8'h04, 3'd2, 0);
        step(0, 0, 8'h04, 8'h04, 3'd2, 0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 0);
        // ptr=3 kept through idle: 3 beats 0
        step(0, 0, 8'h09, 8'h08, 3'd3, 0);
        step(0, 0, 8'h01, 8'h00, 3'd0, 0);
        step(0, 0, 8'h01, 8'h00, 3'd0, 0);
        step(0, 0, 8'h01, 8'h01, 3'd0, 0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 0);

        // full rotation, reset wins over requests
        step(1, 0, 8'hFF, 8'h00, 3'd0, 0);
        for (int h = 0; h <= 8; h++) begin
            step(0, 0, 8'hFF, oh(h % 8), 3'(h % 8), 0);
            step(0, 0, 8'hFF, oh(h % 8), 3'(h % 8), 0);
            step(0, 0, 8'hFF & ~oh(h % 8), 8'h00, 3'd0, 0);
            step(0, 0, 8'hFF, 8'h00, 3'd0, 0);
        end

        // disable handling
        step(1, 0, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h20, 8'h20, 3'd5, 0);
        step(0, 0, 8'h20, 8'h20, 3'd5, 0);
        step(0, 1, 8'h20, 8'h00, 3'd0, 0);
        step(0, 0, 8'h20, 8'h20, 3'd5, 0);
        step(0, 1, 8'hFF, 8'h00, 3'd0, 0);
        step(0, 1, 8'hFF, 8'h00, 3'd0, 0);
        step(0, 0, 8'h20, 8'h20, 3'd5, 0);
        // holder drops under z: ptr stays 0, so 5 beats 6
        step(0, 1, 8'h00, 8'h00, 3'd0, 0);
        step(0, 0, 8'h60, 8'h20, 3'd5, 0);
        step(0, 0, 8'h40, 8'h00, 3'd0, 0);
        step(0, 0, 8'h40, 8'h00, 3'd0, 0);
        step(0, 0, 8'h40, 8'h40, 3'd6, 0);
        step(0, 0, 8'h40, 8'h40, 3'd6, 0);
        // reset mid-grant
        step(1, 0, 8'h41, 8'h00, 3'd0, 0);
        step(0, 0, 8'h41, 8'h01, 3'd0, 0);
        step(0, 0, 8'h41, 8'h01, 3'd0, 0);

        // long hold: timeout build releases after 16 cycles
        step(1, 0, 8'h09, 8'h00, 3'd0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h09, 8'h01, 3'd0, 0);
        end
`ifdef ARB_TIMEOUT_EN
        step(0, 0, 8'h09, 8'h00, 3'd0, 1);
        step(0, 0, 8'h09, 8'h00, 3'd0, 0);
        step(0, 0, 8'h09, 8'h08, 3'd3, 0);
        step(0, 0, 8'h09, 8'h08, 3'd3, 0);
`else
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h09, 8'h01, 3'd0, 0);
        end
`endif

        for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
